// File: rtl/fc8_vram_arbiter_if.sv
// fc8_vram_arbiter_if
// Bundles the three requester ports, the VRAM macro port and the statistics
// outputs of fc8_vram_arbiter. The arbiter connects through the slave modport;
// the requesters/VRAM side (or a testbench) uses the master modport.
interface fc8_vram_arbiter_if #(
  parameter int ADDR_W = 16
);
  // video line fetch (read only)
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  // CPU
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  // blit / DMA engine
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  // shared read data, qualified by the *_rvalid strobes
  logic [7:0]        rdata;
  // VRAM macro port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  // statistics
  logic [15:0]       stat_cpu_wait;
  logic [15:0]       stat_forced;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata,
    output stat_cpu_wait, stat_forced
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata,
    input  stat_cpu_wait, stat_forced
  );
endinterface

// File: rtl/fc8_vram_arbiter.sv
// fc8_vram_arbiter
// Shares the single-port VRAM between video line fetch (vid), CPU (cpu) and
// the blit/DMA engine (dma). Video has strict priority, cpu/dma alternate
// round-robin, and after STARVE_LIMIT consecutive video grants with cpu/dma
// waiting one slot is forced to cpu/dma. Grants are combinational on the
// current requests; read data returns one cycle after the grant, steered by a
// registered {valid, src} tag.
// Optional feature: define VRAM_ARB_STATS_EN to build the saturating
// stat_cpu_wait / stat_forced counters; otherwise both outputs read 16'h0000.
module fc8_vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  fc8_vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_CPU  = 2'd2,
    SRC_DMA  = 2'd3
  } src_e;

  logic [7:0]        vcnt;        // video grants in a row while cpu/dma wait
  logic [7:0]        vcnt_nxt;
  src_e              rr_last;     // last served of cpu/dma
  logic              tag_valid;   // a read was granted last cycle
  src_e              tag_src;     // who that read belongs to
  src_e              rr_win;
  src_e              win;
  logic              nv_pending;
  logic              force_slot;
  logic              mem_en_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [7:0]        mem_wdata_c;

  assign nv_pending = bus.cpu_req | bus.dma_req;
  assign force_slot = (vcnt == 8'(STARVE_LIMIT));

  // Choose the grantee: rr winner of cpu/dma, then video priority or forced slot.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    rr_win = SRC_NONE;
    win    = SRC_NONE;
    if (bus.cpu_req && bus.dma_req) rr_win = (rr_last == SRC_DMA) ? SRC_CPU : SRC_DMA;
    else if (bus.cpu_req)           rr_win = SRC_CPU;
    else if (bus.dma_req)           rr_win = SRC_DMA;
    // nothing is granted while reset is held
    if (!rst) begin
      if (force_slot)       win = rr_win;
      else if (bus.vid_req) win = SRC_VID;
      else                  win = rr_win;
    end
  end

  // Drive the grant pulse and steer the grantee onto the VRAM port (all 0 when idle).
  always_comb begin
    bus.vid_gnt = 1'b0;
    bus.cpu_gnt = 1'b0;
    bus.dma_gnt = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (win)
      SRC_VID: begin
        bus.vid_gnt = 1'b1;
        mem_en_c    = 1'b1;
        mem_addr_c  = bus.vid_addr;
      end
      SRC_CPU: begin
        bus.cpu_gnt = 1'b1;
        mem_en_c    = 1'b1;
        mem_we_c    = bus.cpu_we;
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;
      end
      SRC_DMA: begin
        bus.dma_gnt = 1'b1;
        mem_en_c    = 1'b1;
        mem_we_c    = bus.dma_we;
        mem_addr_c  = bus.dma_addr;
        mem_wdata_c = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  // Starvation counter: count video wins while cpu/dma wait, clear otherwise.
  always_comb begin
    vcnt_nxt = vcnt;
    if (win == SRC_CPU || win == SRC_DMA || !nv_pending) vcnt_nxt = '0;
    else if (win == SRC_VID)                            vcnt_nxt = vcnt + 8'd1;
  end

  // Arbitration state and read-return tag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    if (rst) begin
      vcnt      <= '0;
      rr_last   <= SRC_DMA;       // cpu wins the first tie after reset
      tag_valid <= 1'b0;          // an in-flight read is dropped
      tag_src   <= SRC_NONE;
    end else begin
      vcnt      <= vcnt_nxt;
      if (win == SRC_CPU || win == SRC_DMA) rr_last <= win;
      tag_valid <= mem_en_c && !mem_we_c;
      tag_src   <= win;
    end
  end

  assign bus.vid_rvalid = tag_valid && (tag_src == SRC_VID);
  assign bus.cpu_rvalid = tag_valid && (tag_src == SRC_CPU);
  assign bus.dma_rvalid = tag_valid && (tag_src == SRC_DMA);
  assign bus.rdata      = tag_valid ? bus.mem_rdata : 8'h00;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cpu_wait_q;
  logic [15:0] forced_q;

  // Saturating counters of cpu wait cycles and forced slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_wait_q <= '0;
      forced_q   <= '0;
    end else begin
      if (bus.cpu_req && !bus.cpu_gnt && cpu_wait_q != 16'hFFFF) cpu_wait_q <= cpu_wait_q + 16'd1;
      if (force_slot && forced_q != 16'hFFFF)                   forced_q   <= forced_q + 16'd1;
    end
  end

  assign bus.stat_cpu_wait = cpu_wait_q;
  assign bus.stat_forced   = forced_q;
`else
  assign bus.stat_cpu_wait = 16'h0000;
  assign bus.stat_forced   = 16'h0000;
`endif

endmodule

// File: tb/tb_fc8_vram_arbiter.sv
// tb_fc8_vram_arbiter
// Self-checking bench for fc8_vram_arbiter: directed scenarios plus a
// randomized run, all checked against a cycle-level reference model of the
// arbitration rules and a shadow copy of VRAM contents.
`timescale 1ns/1ps
module tb_fc8_vram_arbiter;

  localparam int ADDR_W = 16;
  localparam int LIMIT  = 8;
  localparam int NONE = 0, VID = 1, CPU = 2, DMA = 3;
`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc8_vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  fc8_vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Power-up VRAM content, a fixed function of the address.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return 8'(a[7:0] * 8'd29 + a[15:8] + 8'h3C);
  endfunction

  // VRAM macro model: synchronous write, read data one cycle after mem_en.
  logic [7:0] vram    [0:65535];
  bit         vram_wr [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        vram[bus.mem_addr]    <= bus.mem_wdata;
        vram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= vram_wr[bus.mem_addr] ? vram[bus.mem_addr] : init_byte(bus.mem_addr);
      end
    end
  end

  // Bench-side shadow of what VRAM must contain.
  logic [7:0] shadow [0:65535];
  bit         sh_wr  [0:65535];
  function automatic logic [7:0] sh_read(input logic [15:0] a);
    return sh_wr[a] ? shadow[a] : init_byte(a);
  endfunction

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } rq_t;

  rq_t         cpu_r, dma_r;
  logic        vid_rq;
  logic [15:0] vid_a;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int         m_run;        // video grants in a row while cpu/dma wait
  bit         m_cpu_first;  // cpu wins the next cpu/dma tie
  bit         m_rd_valid;
  logic [2:0] m_rd_rv;
  logic [7:0] m_rd_data;
  int         m_cpu_wait;
  int         m_forced;

  // per-cycle observed / expected values; bus = {gnt[vid,cpu,dma], en, we, addr, wdata}
  int          e_win;
  logic [28:0] e_bus, o_bus;
  logic [2:0]  e_rv, o_rv;
  logic [7:0]  e_rdata, o_rdata;
  logic [15:0] e_stat_wait, e_stat_forced, o_stat_wait, o_stat_forced;

  task automatic model_reset();
    m_run       = 0;
    m_cpu_first = 1'b1;
    m_rd_valid  = 1'b0;
    m_rd_rv     = 3'b000;
    m_rd_data   = 8'h00;
    m_cpu_wait  = 0;
    m_forced    = 0;
  endtask

  task automatic clear_reqs();
    vid_rq = 1'b0;
    vid_a  = 16'h0000;
    cpu_r  = '0;
    dma_r  = '0;
  endtask

  task automatic drive();
    bus.vid_req   = vid_rq;
    bus.vid_addr  = vid_a;
    bus.cpu_req   = cpu_r.req;
    bus.cpu_we    = cpu_r.we;
    bus.cpu_addr  = cpu_r.addr;
    bus.cpu_wdata = cpu_r.wdata;
    bus.dma_req   = dma_r.req;
    bus.dma_we    = dma_r.we;
    bus.dma_addr  = dma_r.addr;
    bus.dma_wdata = dma_r.wdata;
  endtask

  // One clock cycle: drive requests, sample the DUT, compute expectations, advance the model.
  task automatic step();
    bit          forced;
    int          nv;
    logic        w_we;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    @(negedge clk);
    drive();
    #1;
    cyc++;
    o_bus         = {bus.vid_gnt, bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    o_rv          = {bus.vid_rvalid, bus.cpu_rvalid, bus.dma_rvalid};
    o_rdata       = bus.rdata;
    o_stat_wait   = bus.stat_cpu_wait;
    o_stat_forced = bus.stat_forced;

    forced = (m_run == LIMIT);
    nv = NONE;
    if (cpu_r.req && dma_r.req) nv = m_cpu_first ? CPU : DMA;
    else if (cpu_r.req)         nv = CPU;
    else if (dma_r.req)         nv = DMA;
    e_win = forced ? nv : (vid_rq ? VID : nv);

    w_we = 1'b0; w_addr = 16'h0; w_wdata = 8'h0;
    case (e_win)
      VID: begin w_addr = vid_a; e_bus = {3'b100, 1'b1, 1'b0, vid_a, 8'h00}; end
      CPU: begin w_we = cpu_r.we; w_addr = cpu_r.addr; w_wdata = cpu_r.wdata;
                 e_bus = {3'b010, 1'b1, w_we, w_addr, w_wdata}; end
      DMA: begin w_we = dma_r.we; w_addr = dma_r.addr; w_wdata = dma_r.wdata;
                 e_bus = {3'b001, 1'b1, w_we, w_addr, w_wdata}; end
      default: e_bus = '0;
    endcase
    e_rv          = m_rd_valid ? m_rd_rv : 3'b000;
    e_rdata       = m_rd_data;
    e_stat_wait   = STATS ? 16'(m_cpu_wait) : 16'h0000;
    e_stat_forced = STATS ? 16'(m_forced)   : 16'h0000;

    if (cpu_r.req && e_win != CPU && m_cpu_wait < 65535) m_cpu_wait++;
    if (forced && m_forced < 65535) m_forced++;
    if (e_win == CPU || e_win == DMA || !(cpu_r.req || dma_r.req)) m_run = 0;
    else if (e_win == VID) m_run++;
    if (e_win == CPU)      m_cpu_first = 1'b0;
    else if (e_win == DMA) m_cpu_first = 1'b1;
    m_rd_valid = (e_win != NONE) && !w_we;
    m_rd_rv    = e_bus[28:26];
    if (m_rd_valid) m_rd_data = sh_read(w_addr);
    if (e_win != NONE && w_we) begin
      shadow[w_addr] = w_wdata;
      sh_wr[w_addr]  = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_reqs();
    drive();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    vid_rq = 1'b1; vid_a = 16'h0003;
    cpu_r  = '{req: 1'b1, we: 1'b0, addr: 16'h0010, wdata: 8'h11};
    dma_r  = '{req: 1'b1, we: 1'b1, addr: 16'h0020, wdata: 8'h22};
    drive();
    repeat (3) @(negedge clk);
    #1;
    o_bus = {bus.vid_gnt, bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (o_bus !== 29'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0", o_bus); end
    checks++;
    if ({bus.vid_rvalid, bus.cpu_rvalid, bus.dma_rvalid} !== 3'b000 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rsp rvalid=%b rdata=%h exp 000/00", {bus.vid_rvalid, bus.cpu_rvalid, bus.dma_rvalid}, bus.rdata);
    end
    checks++;
    if (bus.stat_cpu_wait !== 16'h0 || bus.stat_forced !== 16'h0) begin
      errors++;
      $display("FAIL reset_stats got=%h/%h exp 0/0", bus.stat_cpu_wait, bus.stat_forced);
    end
    @(negedge clk);
    clear_reqs();
    drive();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cpu_read();
    clear_reqs();
    cpu_r = '{req: 1'b1, we: 1'b0, addr: 16'h1234, wdata: 8'h00};
    step();
    checks++;
    if (o_bus !== {3'b010, 1'b1, 1'b0, 16'h1234, 8'h00}) begin
      errors++; $display("FAIL cpu_read_gnt got=%h exp=%h", o_bus, {3'b010, 1'b1, 1'b0, 16'h1234, 8'h00});
    end
    clear_reqs();
    step();
    checks++;
    if (o_rv !== 3'b010 || o_rdata !== 8'hA5) begin
      errors++; $display("FAIL cpu_read_data rvalid=%b rdata=%h exp 010/a5", o_rv, o_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    clear_reqs();
    cpu_r = '{req: 1'b1, we: 1'b0, addr: 16'h0005, wdata: 8'h00};
    step();
    checks++;
    if (o_bus[28:26] !== 3'b010) begin errors++; $display("FAIL midrst_gnt got=%b exp=010", o_bus[28:26]); end
    @(posedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (bus.cpu_rvalid !== 1'b0 || bus.mem_en !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold rvalid=%b mem_en=%b gnt=%b exp 0/0/0", bus.cpu_rvalid, bus.mem_en, bus.cpu_gnt);
      end
      @(negedge clk);
    end
    clear_reqs();
    drive();
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      step();
      checks++;
      if (o_rv !== 3'b000) begin errors++; $display("FAIL midrst_after rvalid=%b exp=000", o_rv); end
    end
  endtask

  task automatic test_starvation();
    logic [15:0] fs0;
    logic [2:0]  exp_g;
    clear_reqs();
    step();
    vid_rq = 1'b1; vid_a = 16'h0040;
    cpu_r  = '{req: 1'b1, we: 1'b1, addr: 16'h0041, wdata: 8'h00};
    fs0 = 16'h0;
    for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
      step();
      if (i == 0) fs0 = o_stat_forced;
      exp_g = ((i % (LIMIT + 1)) == LIMIT) ? 3'b010 : 3'b100;
      checks++;
      if (o_bus[28:26] !== exp_g) begin errors++; $display("FAIL starve_gnt i=%0d got=%b exp=%b", i, o_bus[28:26], exp_g); end
      checks++;
      if (o_bus !== e_bus) begin errors++; $display("FAIL starve_bus i=%0d got=%h exp=%h", i, o_bus, e_bus); end
      if (e_win == VID) vid_a = 16'(vid_a + 16'd1);
      if (e_win == CPU) cpu_r.wdata = 8'($urandom);
    end
    clear_reqs();
    step();
    checks++;
    if (16'(o_stat_forced - fs0) !== (STATS ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL starve_stat_forced delta=%0d exp=%0d", 16'(o_stat_forced - fs0), STATS ? 3 : 0);
    end
    checks++;
    if (o_stat_wait !== e_stat_wait || o_stat_forced !== e_stat_forced) begin
      errors++; $display("FAIL starve_stats got=%h/%h exp=%h/%h", o_stat_wait, o_stat_forced, e_stat_wait, e_stat_forced);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    logic [7:0] exp_d;
    pulse_reset();
    cpu_r = '{req: 1'b1, we: 1'b1, addr: 16'h0008, wdata: 8'h5C};
    dma_r = '{req: 1'b1, we: 1'b1, addr: 16'h0009, wdata: 8'hD3};
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b001;
      exp_d = (i % 2 == 0) ? cpu_r.wdata : dma_r.wdata;
      step();
      checks++;
      if (o_bus[28:26] !== exp_g || o_bus[7:0] !== exp_d) begin
        errors++; $display("FAIL rr i=%0d gnt=%b wdata=%h exp %b/%h", i, o_bus[28:26], o_bus[7:0], exp_g, exp_d);
      end
      checks++;
      if (o_bus !== e_bus) begin errors++; $display("FAIL rr_bus i=%0d got=%h exp=%h", i, o_bus, e_bus); end
      if (e_win == CPU) begin cpu_r.wdata = 8'($urandom); cpu_r.addr = 16'($urandom_range(0, 31)); end
      if (e_win == DMA) begin dma_r.wdata = 8'($urandom); dma_r.addr = 16'($urandom_range(0, 31)); end
    end
  endtask

  task automatic test_pipelined_reads();
    logic [2:0] exp_rv;
    clear_reqs();
    step();
    for (int k = 0; k < 6; k++) begin
      vid_rq = (k < 3);
      vid_a  = 16'(k);
      step();
      checks++;
      if (o_bus !== e_bus) begin errors++; $display("FAIL pipe_bus k=%0d got=%h exp=%h", k, o_bus, e_bus); end
      exp_rv = (k >= 1 && k <= 3) ? 3'b100 : 3'b000;
      checks++;
      if (o_rv !== exp_rv || (exp_rv != 3'b000 && o_rdata !== sh_read(16'(k - 1)))) begin
        errors++; $display("FAIL pipe_rsp k=%0d rvalid=%b rdata=%h exp %b/%h", k, o_rv, o_rdata, exp_rv, sh_read(16'(k - 1)));
      end
    end
  endtask

  task automatic test_interleaved();
    logic [2:0]  prev_rv;
    logic [7:0]  prev_d;
    logic [15:0] a;
    clear_reqs();
    step();
    prev_rv = 3'b000;
    prev_d  = 8'h00;
    for (int k = 0; k < 6; k++) begin
      clear_reqs();
      a = 16'(8 + 3 * k);
      if (k < 4 && k % 2 == 0) dma_r = '{req: 1'b1, we: 1'b0, addr: a, wdata: 8'h00};
      if (k < 4 && k % 2 == 1) begin vid_rq = 1'b1; vid_a = a; end
      step();
      checks++;
      if (o_rv !== prev_rv || (prev_rv != 3'b000 && o_rdata !== prev_d)) begin
        errors++; $display("FAIL ilv_rsp k=%0d rvalid=%b rdata=%h exp %b/%h", k, o_rv, o_rdata, prev_rv, prev_d);
      end
      checks++;
      if ($countones(o_rv) > 1) begin errors++; $display("FAIL ilv_onehot k=%0d rvalid=%b exp at most one", k, o_rv); end
      prev_rv = (k >= 4) ? 3'b000 : ((k % 2 == 0) ? 3'b001 : 3'b100);
      prev_d  = sh_read(a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) pulse_reset();
      if (!vid_rq) begin
        vid_rq = ($urandom_range(0, 99) < 75);
        vid_a  = 16'($urandom_range(0, 31));
      end
      if (!cpu_r.req) cpu_r = '{req: ($urandom_range(0, 99) < 40), we: 1'($urandom),
                                addr: 16'($urandom_range(0, 31)), wdata: 8'($urandom)};
      if (!dma_r.req) dma_r = '{req: ($urandom_range(0, 99) < 40), we: 1'($urandom),
                                addr: 16'($urandom_range(0, 31)), wdata: 8'($urandom)};
      step();
      checks++;
      if (o_bus !== e_bus) begin errors++; $display("FAIL rand_bus cyc=%0d got=%h exp=%h", cyc, o_bus, e_bus); end
      checks++;
      if (o_rv !== e_rv || (e_rv != 3'b000 && o_rdata !== e_rdata)) begin
        errors++; $display("FAIL rand_rsp cyc=%0d rvalid=%b rdata=%h exp %b/%h", cyc, o_rv, o_rdata, e_rv, e_rdata);
      end
      if (e_win == VID) vid_rq = 1'b0;
      if (e_win == CPU) cpu_r.req = 1'b0;
      if (e_win == DMA) dma_r.req = 1'b0;
    end
    clear_reqs();
    step();
    checks++;
    if (o_stat_wait !== e_stat_wait || o_stat_forced !== e_stat_forced) begin
      errors++; $display("FAIL rand_stats got=%h/%h exp=%h/%h", o_stat_wait, o_stat_forced, e_stat_wait, e_stat_forced);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_reqs();
    model_reset();
    test_reset();
    test_cpu_read();
    test_reset_mid_read();
    test_starvation();
    test_round_robin();
    test_pipelined_reads();
    test_interleaved();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
